// File: rtl/ct_ifu_icache_refill_wr_if.sv
// ---------------------------------------------------------------------------
// ct_ifu_icache_refill_wr_if
// Signal bundle around the icache refill write sequencer.
//   slave  : sequencer side. It receives the refill command, BIU beats and
//            the arbiter grant, and drives beat ready, the write request,
//            the per-way data-array controls, din, the index and done.
//   master : environment side (refill controller, BIU, arbiter). This is the
//            mirror image of slave.
// ---------------------------------------------------------------------------
interface ct_ifu_icache_refill_wr_if;
   // refill command
   logic          refill_start;
   logic [9:0]    refill_line_idx;
   logic          refill_way;
   logic          refill_wr_done;
   // BIU beat handshake
   logic          biu_beat_vld;
   logic [127:0]  biu_beat_data;
   logic          biu_beat_rdy;
   // array write-port arbitration
   logic          refill_wr_req;
   logic          refill_wr_gnt;
   // data array 0
   logic          ifu_icache_data_array0_bank0_cen_b;
   logic          ifu_icache_data_array0_bank1_cen_b;
   logic          ifu_icache_data_array0_bank2_cen_b;
   logic          ifu_icache_data_array0_bank3_cen_b;
   logic          ifu_icache_data_array0_bank0_clk_en;
   logic          ifu_icache_data_array0_bank1_clk_en;
   logic          ifu_icache_data_array0_bank2_clk_en;
   logic          ifu_icache_data_array0_bank3_clk_en;
   logic          ifu_icache_data_array0_wen_b;
   logic [127:0]  ifu_icache_data_array0_din;
   // data array 1
   logic          ifu_icache_data_array1_bank0_cen_b;
   logic          ifu_icache_data_array1_bank1_cen_b;
   logic          ifu_icache_data_array1_bank2_cen_b;
   logic          ifu_icache_data_array1_bank3_cen_b;
   logic          ifu_icache_data_array1_bank0_clk_en;
   logic          ifu_icache_data_array1_bank1_clk_en;
   logic          ifu_icache_data_array1_bank2_clk_en;
   logic          ifu_icache_data_array1_bank3_clk_en;
   logic          ifu_icache_data_array1_wen_b;
   logic [127:0]  ifu_icache_data_array1_din;
   // shared write index
   logic [15:0]   ifu_icache_index;

   modport slave (
      input  refill_start, refill_line_idx, refill_way,
      input  biu_beat_vld, biu_beat_data, refill_wr_gnt,
      output biu_beat_rdy, refill_wr_req, refill_wr_done,
      output ifu_icache_data_array0_bank0_cen_b, ifu_icache_data_array0_bank1_cen_b,
             ifu_icache_data_array0_bank2_cen_b, ifu_icache_data_array0_bank3_cen_b,
             ifu_icache_data_array0_bank0_clk_en, ifu_icache_data_array0_bank1_clk_en,
             ifu_icache_data_array0_bank2_clk_en, ifu_icache_data_array0_bank3_clk_en,
             ifu_icache_data_array0_wen_b, ifu_icache_data_array0_din,
             ifu_icache_data_array1_bank0_cen_b, ifu_icache_data_array1_bank1_cen_b,
             ifu_icache_data_array1_bank2_cen_b, ifu_icache_data_array1_bank3_cen_b,
             ifu_icache_data_array1_bank0_clk_en, ifu_icache_data_array1_bank1_clk_en,
             ifu_icache_data_array1_bank2_clk_en, ifu_icache_data_array1_bank3_clk_en,
             ifu_icache_data_array1_wen_b, ifu_icache_data_array1_din,
             ifu_icache_index
   );

   modport master (
      output refill_start, refill_line_idx, refill_way,
      output biu_beat_vld, biu_beat_data, refill_wr_gnt,
      input  biu_beat_rdy, refill_wr_req, refill_wr_done,
      input  ifu_icache_data_array0_bank0_cen_b, ifu_icache_data_array0_bank1_cen_b,
             ifu_icache_data_array0_bank2_cen_b, ifu_icache_data_array0_bank3_cen_b,
             ifu_icache_data_array0_bank0_clk_en, ifu_icache_data_array0_bank1_clk_en,
             ifu_icache_data_array0_bank2_clk_en, ifu_icache_data_array0_bank3_clk_en,
             ifu_icache_data_array0_wen_b, ifu_icache_data_array0_din,
             ifu_icache_data_array1_bank0_cen_b, ifu_icache_data_array1_bank1_cen_b,
             ifu_icache_data_array1_bank2_cen_b, ifu_icache_data_array1_bank3_cen_b,
             ifu_icache_data_array1_bank0_clk_en, ifu_icache_data_array1_bank1_clk_en,
             ifu_icache_data_array1_bank2_clk_en, ifu_icache_data_array1_bank3_clk_en,
             ifu_icache_data_array1_wen_b, ifu_icache_data_array1_din,
             ifu_icache_index
   );
endinterface

// File: rtl/ct_ifu_icache_refill_wr.sv
// ---------------------------------------------------------------------------
// ct_ifu_icache_refill_wr
// Refill write sequencer for the L1 icache data arrays. It accepts a 64-byte
// line as four 128-bit BIU beats into a 2-entry FIFO. For each granted cycle
// it writes one beat into the selected way, then pulses done.
// Ports:
//   forever_cpuclk : block clock (ungated source for the array ICGs)
//   cpurst         : synchronous active-high reset
//   bus            : slave modport of ct_ifu_icache_refill_wr_if. It carries
//                    the refill command, beat handshake, write req/gnt,
//                    per-way array controls, din, the index and done.
// ---------------------------------------------------------------------------
module ct_ifu_icache_refill_wr (
   input  logic                            forever_cpuclk,
   input  logic                            cpurst,
   ct_ifu_icache_refill_wr_if.slave        bus
);

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t        state;
   logic [127:0]  fifo_mem [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    count;
   logic [2:0]    in_cnt;
   logic [1:0]    out_cnt;
   logic [9:0]    line_idx;
   logic          way;

   // registered array-side outputs
   logic          wr0;
   logic          wr1;
   logic [127:0]  din0;
   logic [127:0]  din1;
   logic [15:0]   index;
   logic          done;

   logic          push;
   logic          pop;

   assign bus.biu_beat_rdy  = (state == FILL) && (count < 2'd2) && (in_cnt < 3'd4);
   assign bus.refill_wr_req = (state == FILL) && (count != 2'd0);
   assign push = bus.biu_beat_vld && bus.biu_beat_rdy;
   assign pop  = bus.refill_wr_req && bus.refill_wr_gnt;

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         state    <= IDLE;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         count    <= '0;
         in_cnt   <= '0;
         out_cnt  <= '0;
         line_idx <= '0;
         way      <= 1'b0;
         wr0      <= 1'b0;
         wr1      <= 1'b0;
         din0     <= '0;
         din1     <= '0;
         index    <= '0;
         done     <= 1'b0;
      end else begin
         wr0  <= 1'b0;
         wr1  <= 1'b0;
         done <= 1'b0;

         if (push) begin
            fifo_mem[wr_ptr] <= bus.biu_beat_data;
            wr_ptr           <= ~wr_ptr;
            in_cnt           <= in_cnt + 3'd1;
         end

         // The FIFO head goes to the array outputs in the cycle after the pop.
         // The index uses the out_cnt value from before the increment.
         if (pop) begin
            rd_ptr  <= ~rd_ptr;
            out_cnt <= out_cnt + 2'd1;
            index   <= {line_idx, out_cnt, 4'b0000};
            if (way) begin
               wr1  <= 1'b1;
               din1 <= fifo_mem[rd_ptr];
            end else begin
               wr0  <= 1'b1;
               din0 <= fifo_mem[rd_ptr];
            end
         end

         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase

         case (state)
            IDLE: begin
               if (bus.refill_start) begin
                  state    <= FILL;
                  line_idx <= bus.refill_line_idx;
                  way      <= bus.refill_way;
                  in_cnt   <= '0;
                  out_cnt  <= '0;
               end
            end
            FILL: begin
               if (pop && (out_cnt == 2'd3)) state <= DONE;
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ifu_icache_data_array0_bank0_cen_b  = ~wr0;
   assign bus.ifu_icache_data_array0_bank1_cen_b  = ~wr0;
   assign bus.ifu_icache_data_array0_bank2_cen_b  = ~wr0;
   assign bus.ifu_icache_data_array0_bank3_cen_b  = ~wr0;
   assign bus.ifu_icache_data_array0_bank0_clk_en = wr0;
   assign bus.ifu_icache_data_array0_bank1_clk_en = wr0;
   assign bus.ifu_icache_data_array0_bank2_clk_en = wr0;
   assign bus.ifu_icache_data_array0_bank3_clk_en = wr0;
   assign bus.ifu_icache_data_array0_wen_b        = ~wr0;
   assign bus.ifu_icache_data_array0_din          = din0;

   assign bus.ifu_icache_data_array1_bank0_cen_b  = ~wr1;
   assign bus.ifu_icache_data_array1_bank1_cen_b  = ~wr1;
   assign bus.ifu_icache_data_array1_bank2_cen_b  = ~wr1;
   assign bus.ifu_icache_data_array1_bank3_cen_b  = ~wr1;
   assign bus.ifu_icache_data_array1_bank0_clk_en = wr1;
   assign bus.ifu_icache_data_array1_bank1_clk_en = wr1;
   assign bus.ifu_icache_data_array1_bank2_clk_en = wr1;
   assign bus.ifu_icache_data_array1_bank3_clk_en = wr1;
   assign bus.ifu_icache_data_array1_wen_b        = ~wr1;
   assign bus.ifu_icache_data_array1_din          = din1;

   assign bus.ifu_icache_index = index;
   assign bus.refill_wr_done   = done;

endmodule

// File: tb/tb_ct_ifu_icache_refill_wr.sv
// ---------------------------------------------------------------------------
// tb_ct_ifu_icache_refill_wr
// Bench for the icache refill write sequencer. A cycle-level line-refill
// model (queue-based FIFO, beat/write tallies) predicts rdy, req, done,
// array controls, din and index every cycle.
// ---------------------------------------------------------------------------
module tb_ct_ifu_icache_refill_wr;

   localparam int M_IDLE = 0;
   localparam int M_FILL = 1;
   localparam int M_DONE = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ct_ifu_icache_refill_wr_if bif ();

   ct_ifu_icache_refill_wr dut (
      .forever_cpuclk (clk),
      .cpurst         (rst),
      .bus            (bif)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // {cen_b[3:0], clk_en[3:0], wen_b} for one way
   function automatic logic [8:0] way_ctrl(input logic active);
      return active ? {4'h0, 4'hF, 1'b0} : {4'hF, 4'h0, 1'b1};
   endfunction

   // ------------------------------------------------------------------
   // reference model
   // ------------------------------------------------------------------
   bit            armed = 0;
   int            m_mode = M_IDLE;
   logic [127:0]  q[$];
   int            acc = 0;
   int            nwr = 0;
   logic [9:0]    m_line = '0;
   logic          m_way = 1'b0;
   logic          p_wr = 1'b0;
   logic          p_way = 1'b0;
   logic          p_done = 1'b0;
   logic [15:0]   p_idx = '0;
   logic [127:0]  p_din0 = '0;
   logic [127:0]  p_din1 = '0;
   logic          exp_rdy, exp_req;
   logic [8:0]    obs0, obs1;
   logic [127:0]  head;

   always @(negedge clk) begin
      exp_rdy = (m_mode == M_FILL) && (q.size() < 2) && (acc < 4);
      exp_req = (m_mode == M_FILL) && (q.size() != 0);
      if (armed) begin
         obs0 = {bif.ifu_icache_data_array0_bank0_cen_b, bif.ifu_icache_data_array0_bank1_cen_b,
                 bif.ifu_icache_data_array0_bank2_cen_b, bif.ifu_icache_data_array0_bank3_cen_b,
                 bif.ifu_icache_data_array0_bank0_clk_en, bif.ifu_icache_data_array0_bank1_clk_en,
                 bif.ifu_icache_data_array0_bank2_clk_en, bif.ifu_icache_data_array0_bank3_clk_en,
                 bif.ifu_icache_data_array0_wen_b};
         obs1 = {bif.ifu_icache_data_array1_bank0_cen_b, bif.ifu_icache_data_array1_bank1_cen_b,
                 bif.ifu_icache_data_array1_bank2_cen_b, bif.ifu_icache_data_array1_bank3_cen_b,
                 bif.ifu_icache_data_array1_bank0_clk_en, bif.ifu_icache_data_array1_bank1_clk_en,
                 bif.ifu_icache_data_array1_bank2_clk_en, bif.ifu_icache_data_array1_bank3_clk_en,
                 bif.ifu_icache_data_array1_wen_b};
         check("beat_rdy", 128'(bif.biu_beat_rdy), 128'(exp_rdy));
         check("wr_req", 128'(bif.refill_wr_req), 128'(exp_req));
         check("wr_done", 128'(bif.refill_wr_done), 128'(p_done));
         check("array0_ctrl", 128'(obs0), 128'(way_ctrl(p_wr && !p_way)));
         check("array1_ctrl", 128'(obs1), 128'(way_ctrl(p_wr && p_way)));
         check("index", 128'(bif.ifu_icache_index), 128'(p_idx));
         check("din0", bif.ifu_icache_data_array0_din, p_din0);
         check("din1", bif.ifu_icache_data_array1_din, p_din1);
      end

      // predict the cycle after the coming clock edge
      if (rst) begin
         armed  = 1;
         m_mode = M_IDLE;
         q.delete();
         acc = 0;
         nwr = 0;
         p_wr = 1'b0;
         p_done = 1'b0;
         p_idx = '0;
         p_din0 = '0;
         p_din1 = '0;
      end else if (armed) begin
         p_done = (m_mode == M_DONE);
         p_wr   = 1'b0;
         case (m_mode)
            M_IDLE: begin
               if (bif.refill_start) begin
                  m_mode = M_FILL;
                  m_line = bif.refill_line_idx;
                  m_way  = bif.refill_way;
                  acc = 0;
                  nwr = 0;
               end
            end
            M_FILL: begin
               if (exp_req && bif.refill_wr_gnt) begin
                  head  = q.pop_front();
                  p_wr  = 1'b1;
                  p_way = m_way;
                  p_idx = 16'(int'(m_line) * 64 + nwr * 16);
                  if (m_way) p_din1 = head;
                  else       p_din0 = head;
                  nwr++;
                  if (nwr == 4) m_mode = M_DONE;
               end
               if (exp_rdy && bif.biu_beat_vld) begin
                  q.push_back(bif.biu_beat_data);
                  acc++;
               end
            end
            default: m_mode = M_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // stimulus
   // ------------------------------------------------------------------
   logic [127:0] beat_data [4];

   task automatic step(output logic accepted, output logic done_seen);
      @(negedge clk);
      accepted  = bif.biu_beat_vld && bif.biu_beat_rdy;
      done_seen = bif.refill_wr_done;
      @(posedge clk);
      #1;
   endtask

   // kind: 0 grant always, 1 grant stall, 2 ignored start, 3 reset after 2 writes,
   //       4 random valid/grant
   task automatic do_refill(input logic [9:0] line, input logic way, input int kind);
      int   bi;
      int   dones;
      int   post;
      logic a, d;
      bi = 0;
      dones = 0;
      post = 0;
      bif.refill_start    = 1'b1;
      bif.refill_line_idx = line;
      bif.refill_way      = way;
      bif.biu_beat_vld    = 1'b0;
      bif.refill_wr_gnt   = (kind == 4) ? 1'($urandom_range(0, 1)) : 1'b1;
      step(a, d);
      bif.refill_start = 1'b0;
      for (int cyc = 0; cyc < 80; cyc++) begin
         bif.biu_beat_vld = (bi < 4) && ((kind != 4) || ($urandom_range(0, 2) != 0));
         if (bi < 4) bif.biu_beat_data = beat_data[bi];
         else        bif.biu_beat_data = {$urandom, $urandom, $urandom, $urandom};
         case (kind)
            1:       bif.refill_wr_gnt = !((cyc >= 1) && (cyc <= 5));
            4:       bif.refill_wr_gnt = ($urandom_range(0, 2) != 0);
            default: bif.refill_wr_gnt = 1'b1;
         endcase
         if (kind == 2 && cyc == 2) begin
            bif.refill_start    = 1'b1;
            bif.refill_line_idx = ~line;
            bif.refill_way      = ~way;
         end else begin
            bif.refill_start = 1'b0;
         end
         rst = (kind == 3 && cyc == 3);
         step(a, d);
         if (a) bi++;
         if (d) dones++;
         if (kind == 3 && cyc == 3) begin
            rst = 1'b0;
            bif.biu_beat_vld = 1'b0;
            for (int k = 0; k < 6; k++) begin
               step(a, d);
               if (d) dones++;
            end
            check("reset_no_done", 128'(dones), 128'(0));
            return;
         end
         if (dones > 0) post++;
         if (post == 4) break;
      end
      bif.biu_beat_vld  = 1'b0;
      bif.refill_start  = 1'b0;
      check("beats_accepted", 128'(bi), 128'(4));
      check("done_pulses", 128'(dones), 128'(1));
   endtask

   initial begin
      logic a, d;
      bif.refill_start    = 1'b0;
      bif.refill_line_idx = '0;
      bif.refill_way      = 1'b0;
      bif.biu_beat_vld    = 1'b0;
      bif.biu_beat_data   = '0;
      bif.refill_wr_gnt   = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      step(a, d);

      // basic refill, way 0, line 0x155
      for (int i = 0; i < 4; i++) beat_data[i] = {{31{4'hA}}, 4'(i)};
      do_refill(10'h155, 1'b0, 0);

      // grant stall, way 1
      for (int i = 0; i < 4; i++) beat_data[i] = {$urandom, $urandom, $urandom, $urandom};
      do_refill(10'h2A3, 1'b1, 1);

      // start pulsed during FILL
      for (int i = 0; i < 4; i++) beat_data[i] = {$urandom, $urandom, $urandom, $urandom};
      do_refill(10'h0F0, 1'b0, 2);

      // reset after two writes
      for (int i = 0; i < 4; i++) beat_data[i] = {$urandom, $urandom, $urandom, $urandom};
      do_refill(10'h3C1, 1'b1, 3);

      // grant and beats while idle
      bif.refill_wr_gnt = 1'b1;
      bif.biu_beat_vld  = 1'b1;
      repeat (5) step(a, d);
      bif.biu_beat_vld  = 1'b0;

      // randomized refills
      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < 4; i++) beat_data[i] = {$urandom, $urandom, $urandom, $urandom};
         do_refill(10'($urandom), 1'($urandom), 4);
         bif.refill_wr_gnt = 1'($urandom);
         repeat ($urandom_range(0, 3)) step(a, d);
      end

      repeat (3) step(a, d);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
